// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: single-cycle ALU results (A) take priority over
// FIFO-buffered long-latency results (B); a scoreboard tracks destinations owed by B.
module wb_arbiter #(
    parameter int BDEPTH = 2,
    parameter int XLEN   = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            a_valid,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [4:0]      b_rd,
    input  logic [XLEN-1:0] b_data,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      q_rs1,
    input  logic [4:0]      q_rs2,
    output logic            busy1,
    output logic            busy2,
    output logic            we3,
    output logic [4:0]      A3,
    output logic [XLEN-1:0] WD3
);

    localparam int AW = $clog2(BDEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [4:0]      fifo_rd   [BDEPTH];
    logic [XLEN-1:0] fifo_data [BDEPTH];
    logic            full, empty, push, pop;

    logic            sel_valid;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic            b_out;

    logic [31:0]     pend, pend_next;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign b_ready = !full;
    assign push    = b_valid && !full;
    assign pop     = !a_valid && !empty;

    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (a_valid) begin
            sel_valid = 1'b1;
            sel_rd    = a_rd;
            sel_data  = a_data;
        end else if (!empty) begin
            sel_valid = 1'b1;
            sel_rd    = fifo_rd[rd_ptr[AW-1:0]];
            sel_data  = fifo_data[rd_ptr[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr[AW-1:0]]   <= b_rd;
            fifo_data[wr_ptr[AW-1:0]] <= b_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3   <= 1'b0;
            A3    <= '0;
            WD3   <= '0;
            b_out <= 1'b0;
        end else begin
            we3   <= sel_valid && (sel_rd != 5'd0);
            b_out <= pop;
            if (sel_valid) begin
                A3  <= sel_rd;
                WD3 <= sel_data;
            end
        end
    end

    // Set is applied after clear so a fresh issue to the same register wins.
    always_comb begin
        pend_next = pend;
        if (we3 && b_out)
            pend_next[A3] = 1'b0;
        if (iss_valid && (iss_rd != 5'd0))
            pend_next[iss_rd] = 1'b1;
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pend <= '0;
        else
            pend <= pend_next;
    end

    assign busy1 = (q_rs1 != 5'd0) && pend[q_rs1];
    assign busy2 = (q_rs2 != 5'd0) && pend[q_rs2];

endmodule
